// File: rtl/lzss_token_packer.sv
// LZSS token packer: packs literal / back-reference tokens MSB-first
// into fixed OUT_WIDTH words; flush emits a zero-padded final word.
//
// Ports:
//   clk, rst                 rising-edge clock, sync active-high reset
//   in_valid/in_ready        token handshake
//   in_is_ref                0 = literal {0,in_data}
//                            1 = reference {1,in_offset,in_length}
//   flush                    one-cycle request to emit residual bits
//   out_valid/out_ready      packed word handshake
//   out_data/out_nbits       packed word (first bit in MSB), meaningful bits
//   out_last                 final word of a flush
//   flush_done               one-cycle pulse when a flush completes
//   bit_count                total accepted token bits (wraps)
module lzss_token_packer #(
    parameter int WORD_SIZE   = 8,
    parameter int OFFSET_BITS = 4,
    parameter int LENGTH_BITS = 2,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_is_ref,
    input  logic [WORD_SIZE-1:0]           in_data,
    input  logic [OFFSET_BITS-1:0]         in_offset,
    input  logic [LENGTH_BITS-1:0]         in_length,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0] out_nbits,
    output logic                           out_last,
    output logic                           flush_done,
    output logic [31:0]                    bit_count
);

    localparam int REF_W   = OFFSET_BITS + LENGTH_BITS;
    localparam int PAY_W   = (WORD_SIZE > REF_W) ? WORD_SIZE : REF_W;
    localparam int TOK_MAX = 1 + PAY_W;
    localparam int ACC_W   = OUT_WIDTH + TOK_MAX - 1;
    localparam int FILL_W  = $clog2(ACC_W + 1);
    localparam int NB_W    = $clog2(OUT_WIDTH + 1);

    localparam logic [FILL_W-1:0] L_OW  = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] L_ACC = FILL_W'(ACC_W);
    localparam logic [FILL_W-1:0] L_LIT = FILL_W'(1 + WORD_SIZE);
    localparam logic [FILL_W-1:0] L_REF = FILL_W'(1 + REF_W);

    typedef enum logic [1:0] {
        S_ACCUM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;

    logic                r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [NB_W-1:0]     r_out_nbits;
    logic                r_out_last;
    logic [31:0]         r_bit_count;

    logic [TOK_MAX-1:0]  w_tok;
    logic [ACC_W-1:0]    w_tok_ext;
    logic [FILL_W-1:0]   w_tok_w;
    logic [FILL_W-1:0]   w_shamt;
    logic                w_free;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_load;
    logic                w_load_last;
    logic [NB_W-1:0]     w_load_nbits;

    // Token right-aligned in TOK_MAX bits; unused upper bits stay zero.
    always_comb begin
        w_tok = '0;
        if (in_is_ref) begin
            w_tok[REF_W:0] = {1'b1, in_offset, in_length};
        end else begin
            w_tok[WORD_SIZE:0] = {1'b0, in_data};
        end
    end

    assign w_tok_w   = in_is_ref ? L_REF : L_LIT;
    assign w_tok_ext = {{(ACC_W-TOK_MAX){1'b0}}, w_tok};
    // Accumulator is left-aligned: new token lands just below the fill.
    assign w_shamt   = L_ACC - r_fill - w_tok_w;
    assign w_free    = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_fill_nxt   = r_fill;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_load_last  = 1'b0;
        w_load_nbits = NB_W'(OUT_WIDTH);
        unique case (r_state)
            S_ACCUM: begin
                w_in_ready = (r_fill < L_OW);
                w_accept   = in_valid && w_in_ready;
                // Accept and drain are exclusive: ready is low when full.
                if (w_accept) begin
                    w_acc_nxt  = r_acc | (w_tok_ext << w_shamt);
                    w_fill_nxt = r_fill + w_tok_w;
                end else if (r_fill >= L_OW && w_free) begin
                    w_load     = 1'b1;
                    w_acc_nxt  = r_acc << OUT_WIDTH;
                    w_fill_nxt = r_fill - L_OW;
                end
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fill >= L_OW) begin
                    if (w_free) begin
                        w_load     = 1'b1;
                        w_acc_nxt  = r_acc << OUT_WIDTH;
                        w_fill_nxt = r_fill - L_OW;
                    end
                end else if (r_fill != '0) begin
                    if (w_free) begin
                        w_load       = 1'b1;
                        w_load_last  = 1'b1;
                        w_load_nbits = NB_W'(r_fill);
                        w_acc_nxt    = '0;
                        w_fill_nxt   = '0;
                    end
                end else if (w_free) begin
                    // Any held word is taken this edge; flush is complete.
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_ACCUM;
                w_acc_nxt   = '0;
                w_fill_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_nbits <= '0;
            r_out_last  <= 1'b0;
            r_bit_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_fill  <= w_fill_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc[ACC_W-1 -: OUT_WIDTH];
                r_out_nbits <= w_load_nbits;
                r_out_last  <= w_load_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_bit_count <= r_bit_count + 32'(w_tok_w);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_nbits  = r_out_nbits;
    assign out_last   = r_out_last;
    assign flush_done = (r_state == S_DONE);
    assign bit_count  = r_bit_count;

endmodule

// File: tb/tb_lzss_token_packer.sv
// Bench for lzss_token_packer: directed scenarios plus random tokens,
// checked by a bit-queue reference model and an output scoreboard.
module tb_lzss_token_packer;

    localparam int TMO = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_ref = 1'b0;
    logic [7:0]  in_data = '0;
    logic [3:0]  in_offset = '0;
    logic [1:0]  in_length = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_nbits;
    logic        out_last;
    logic        flush_done;
    logic [31:0] bit_count;

    lzss_token_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_ref  (in_is_ref),
        .in_data    (in_data),
        .in_offset  (in_offset),
        .in_length  (in_length),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nbits  (out_nbits),
        .out_last   (out_last),
        .flush_done (flush_done),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  nb;
        logic        last;
    } wexp_t;

    wexp_t       exp_q[$];
    bit          mbits[$];
    int          exp_flush = 0;
    int unsigned exp_bits = 0;
    bit          use_model = 0;
    bit          rand_ready = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void chk(string nm, logic [63:0] a,
                                logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
        end
    endfunction

    function automatic void push_exp(logic [31:0] d, int nb, bit last);
        wexp_t w;
        w.d = d;
        w.nb = 6'(nb);
        w.last = last;
        exp_q.push_back(w);
    endfunction

    // Reference: a plain FIFO of bits; every 32 bits form one word.
    function automatic void model_tok(bit r, logic [7:0] d,
                                      logic [3:0] o, logic [1:0] l);
        logic [8:0]  v;
        logic [31:0] wd;
        int          w;
        if (r) begin
            v = {2'b00, 1'b1, o, l};
            w = 7;
        end else begin
            v = {1'b0, d};
            w = 9;
        end
        exp_bits += w;
        if (use_model) begin
            for (int i = w - 1; i >= 0; i--) mbits.push_back(v[i]);
            while (mbits.size() >= 32) begin
                wd = '0;
                for (int i = 0; i < 32; i++)
                    wd = {wd[30:0], mbits.pop_front()};
                push_exp(wd, 32, 1'b0);
            end
        end
    endfunction

    function automatic void model_flush();
        logic [31:0] wd;
        int          n;
        if (use_model) begin
            n = mbits.size();
            if (n > 0) begin
                wd = '0;
                for (int i = 0; i < 32; i++)
                    wd = {wd[30:0], (i < n) ? mbits[i] : 1'b0};
                push_exp(wd, n, 1'b1);
            end
        end
        mbits.delete();
        exp_flush++;
    endfunction

    // Monitor / scoreboard.
    bit          prev_hold = 0;
    bit          prev_done = 0;
    logic [38:0] held;

    always @(negedge clk) begin
        wexp_t w;
        if (rst) begin
            prev_hold = 0;
            prev_done = 0;
        end else begin
            if (prev_hold && out_valid)
                chk("hold_stable", {out_data, out_nbits, out_last}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {out_data, out_nbits, out_last}, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", out_data, w.d);
                    chk("word_nbits", out_nbits, w.nb);
                    chk("word_last", out_last, w.last);
                end
            end
            prev_hold = out_valid && !out_ready;
            held = {out_data, out_nbits, out_last};
            if (flush_done) begin
                chk("done_width", prev_done, 0);
                if (exp_flush == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_words_left", exp_q.size(), 0);
                    exp_flush--;
                end
            end
            prev_done = flush_done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input bit r, input logic [7:0] d,
                        input logic [3:0] o, input logic [1:0] l,
                        input bit fl);
        int k = 0;
        bit ok = 0;
        in_valid = 1;
        in_is_ref = r;
        in_data = d;
        in_offset = o;
        in_length = l;
        flush = fl;
        while (!ok && k < TMO) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                model_tok(r, d, o, l);
                if (fl) model_flush();
            end
            cyc();
            flush = 0;
            k++;
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic flush_req();
        flush = 1;
        model_flush();
        cyc();
        flush = 0;
    endtask

    task automatic wait_flush();
        int k = 0;
        while (exp_flush != 0 && k < TMO) begin
            cyc();
            k++;
        end
        chk("flush_complete", exp_flush, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        mbits.delete();
        exp_q.delete();
        exp_flush = 0;
        exp_bits = 0;
        cyc();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nbits", out_nbits, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_bit_count", bit_count, 0);
        cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        cyc();
    endtask

    task automatic run_s2();
        use_model = 0;
        out_ready = 1;
        push_exp(32'h20908864, 32, 1'b0);
        push_exp(32'h40000000, 4, 1'b1);
        send(0, 8'h41, 0, 0, 0);
        send(0, 8'h42, 0, 0, 0);
        send(0, 8'h43, 0, 0, 0);
        send(0, 8'h44, 0, 0, 0);
        flush_req();
        wait_flush();
        chk("s2_bit_count", bit_count, 36);
    endtask

    initial begin
        // 1 + 2: reset, four literals then flush
        do_reset();
        run_s2();

        // 3: five references with backpressure
        out_ready = 0;
        push_exp(32'hAF5EBD7A, 32, 1'b0);
        for (int i = 0; i < 5; i++) send(1, 0, 4'd5, 2'd3, 0);
        @(negedge clk);
        chk("s3_ready_low", in_ready, 0);
        @(negedge clk);
        chk("s3_valid", out_valid, 1);
        chk("s3_data", out_data, 32'hAF5EBD7A);
        repeat (3) cyc();
        out_ready = 1;
        cyc();
        push_exp(32'hE0000000, 3, 1'b1);
        flush_req();
        wait_flush();

        // 4: flush with empty accumulator
        flush = 1;
        model_flush();
        cyc();
        flush = 0;
        @(negedge clk);
        chk("s4_done_early", flush_done, 0);
        chk("s4_no_valid_a", out_valid, 0);
        @(negedge clk);
        chk("s4_done_pulse", flush_done, 1);
        chk("s4_no_valid_b", out_valid, 0);
        @(negedge clk);
        chk("s4_done_end", flush_done, 0);
        chk("s4_ready", in_ready, 1);
        cyc();

        // 5: flush together with one literal
        push_exp(32'h2A800000, 9, 1'b1);
        send(0, 8'h55, 0, 0, 1);
        wait_flush();
        chk("s5_bit_count", bit_count, exp_bits);

        // 6: reset with a held word and fill of 20
        out_ready = 0;
        for (int i = 0; i < 5; i++) send(0, 8'(8'h30 + i), 0, 0, 0);
        send(1, 0, 4'd9, 2'd1, 0);
        @(negedge clk);
        chk("s6_valid_before", out_valid, 1);
        cyc();
        do_reset();
        run_s2();

        // Random tokens against the bit-queue model
        use_model = 1;
        rand_ready = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush_req();
                wait_flush();
            end else begin
                send($urandom_range(0, 1) == 1,
                     8'($urandom), 4'($urandom), 2'($urandom), 0);
                if ($urandom_range(0, 5) == 0) cyc();
            end
        end
        flush_req();
        wait_flush();
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_bit_count", bit_count, exp_bits);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
